sparc_fetch_unit: RTL and testbench
===================================

// Module: sparc_fetch_unit
// PURPOSE
//  Instruction Fetch stage; sits directly upstream of the IF/ID pipeline register.
//  Owns the SPARC PC/nPC pair and runs a req/ack handshake to instruction memory.
//  Presents a registered fetch buffer (PC, nPC, instruction, valid) that IF/ID latches.
//  Implements delayed control transfer (delay slot), annul, hazard stall and fetch timeout.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded at reset; nPC resets to RESET_PC+4
//  NOP_INSTR    32'h0100_0000  bubble encoding (sethi 0,%g0) driven when if_valid=0
//  ACK_TIMEOUT  15             max cycles imem_req may stay high without imem_ack
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low (0 = in reset)
//  stall        in   1   hazard stall from ID; 1 = hold fetch buffer and PC/nPC
//  br_taken     in   1   1-cycle pulse: control transfer resolved taken for branch now in ID
//  br_annul     in   1   valid with br_taken; 1 = squash the delay-slot instruction
//  br_target    in   32  transfer target, word aligned
//  imem_req     out  1   fetch request
//  imem_addr    out  32  fetch address (= PC), stable while imem_req=1
//  imem_ack     in   1   fetch complete; imem_rdata valid in the same cycle
//  imem_rdata   in   32  fetched instruction word
//  if_pc        out  32  PC of instruction in fetch buffer
//  if_npc       out  32  nPC associated with that instruction
//  if_instr     out  32  instruction in fetch buffer (NOP_INSTR when invalid)
//  if_valid     out  1   fetch buffer holds a real instruction
//  if_id_le     out  1   load enable to IF/ID register (= ~stall)
//  fetch_err    out  1   sticky timeout flag
// BEHAVIOUR
//  Reset (async, immediate): PC=RESET_PC, nPC=RESET_PC+4, state=IDLE, imem_req=0,
//    imem_addr=RESET_PC, if_pc=0, if_npc=0, if_instr=NOP_INSTR, if_valid=0, fetch_err=0, tmo_cnt=0.
//    Reset asserted mid-request drops imem_req at once; the pending ack is ignored.
//  FSM states: IDLE, REQ, HOLD, ERR.
//  IDLE: one cycle after reset release, then -> REQ.
//  REQ: imem_req=1, imem_addr=PC. On the edge where imem_ack=1:
//    - buffer <= {PC, nPC, imem_rdata}, if_valid<=1, PC<=nPC, nPC<=nPC+4 (mod 2^32).
//    - stall=1 that cycle -> HOLD, else stay REQ (zero-wait ack gives 1 instr/cycle).
//    - No ack: tmo_cnt++; on the edge where tmo_cnt reaches ACK_TIMEOUT -> ERR.
//    - No ack and stall=1: remain in REQ, buffer unchanged.
//  HOLD: imem_req=0; buffer, PC and nPC frozen; stall=0 -> REQ.
//  ERR: imem_req=0, if_valid=0, if_instr=NOP_INSTR, fetch_err=1; exit only by reset.
//  tmo_cnt clears on every ack and on every exit from REQ.
//  Latency: ack at edge t -> if_instr/if_valid updated after edge t; IF/ID latches at edge t+1.
//  Delayed transfer (br_taken=1, br_annul=0), delay slot = current PC:
//    - no ack this cycle: nPC<=br_target, PC unchanged (delay slot is fetched next).
//    - ack this cycle (delay slot completing): PC<=br_target, nPC<=br_target+4.
//  Annulled transfer (br_taken=1, br_annul=1):
//    - ack this cycle: delay-slot data discarded, buffer <= NOP_INSTR/if_valid=0, PC<=br_target,
//      nPC<=br_target+4.
//    - no ack: set annul_pend; PC/nPC redirected only when the outstanding fetch acks
//      (imem_addr stays stable); that ack's data is discarded as above.
//  br_taken while stall=1 or in IDLE/HOLD/ERR is ignored (ID must not resolve while stalled).
//  if_id_le = ~stall combinationally in every state, including reset.
//  Address wrap: nPC+4 at 32'hFFFF_FFFC wraps to 0; no error.
// TESTING
//  1. Reset release, imem_ack tied 1 -> imem_addr 0,4,8,C on consecutive cycles; if_pc lags one cycle.
//  2. stall=1 for 3 cycles after fetching addr 8 -> if_pc=8 held, imem_req=0, if_id_le=0; addr C next.
//  3. Branch at 0x10, br_taken, target 0x40 -> fetch order 0x14 (delay slot, valid), 0x40, 0x44.
//  4. Same with br_annul=1, ack delayed 2 cycles -> 0x14 fetched, if_valid=0/NOP, then 0x40.
//  5. imem_ack held 0 for 15 cycles -> fetch_err=1, imem_req=0; reset low clears fetch_err=0.
//  6. Assert reset while imem_req=1, ack arrives during reset -> ignored; restart at RESET_PC.

Source files
------------

// File: rtl/sparc_fetch_unit.sv
// SPARC instruction fetch stage: PC/nPC pair, imem req/ack handshake and the
// registered fetch buffer consumed by IF/ID, with delay-slot, annul, stall and timeout.
module sparc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0100_0000,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        br_annul,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_npc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        if_id_le,
  output logic        fetch_err
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   npc;
  logic [31:0]   pend_target;
  logic          annul_pend;
  logic [TW-1:0] tmo_cnt;

  logic          br_now;
  logic          annul_now;
  logic [31:0]   redirect;

  // ID only resolves transfers while not stalled; anything else is ignored
  assign br_now    = br_taken && !stall && (state == REQ);
  assign annul_now = annul_pend || (br_now && br_annul);
  assign redirect  = annul_pend ? pend_target : br_target;

  assign imem_addr = pc;
  assign if_id_le  = ~stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      npc         <= RESET_PC + 32'd4;
      pend_target <= '0;
      annul_pend  <= 1'b0;
      tmo_cnt     <= '0;
      imem_req    <= 1'b0;
      if_pc       <= '0;
      if_npc      <= '0;
      if_instr    <= NOP_INSTR;
      if_valid    <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end

        REQ: begin
          if (imem_ack) begin
            tmo_cnt    <= '0;
            annul_pend <= 1'b0;
            if_pc      <= pc;
            if_npc     <= npc;
            if (annul_now) begin
              if_instr <= NOP_INSTR;
              if_valid <= 1'b0;
              pc       <= redirect;
              npc      <= redirect + 32'd4;
            end else begin
              if_instr <= imem_rdata;
              if_valid <= 1'b1;
              if (br_now) begin
                pc  <= br_target;
                npc <= br_target + 32'd4;
              end else begin
                pc  <= npc;
                npc <= npc + 32'd4;
              end
            end
            if (stall) begin
              state    <= HOLD;
              imem_req <= 1'b0;
            end
          end else begin
            // Outstanding fetch keeps imem_addr stable; annul redirect waits for its ack
            if (br_now) begin
              if (br_annul) begin
                annul_pend  <= 1'b1;
                pend_target <= br_target;
              end else begin
                npc <= br_target;
              end
            end
            if (tmo_cnt == TMO_LAST) begin
              state      <= ERR;
              imem_req   <= 1'b0;
              tmo_cnt    <= '0;
              annul_pend <= 1'b0;
              if_valid   <= 1'b0;
              if_instr   <= NOP_INSTR;
              fetch_err  <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end

        HOLD: begin
          if (!stall) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end

        ERR: begin
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparc_fetch_unit.sv
// Directed bench for sparc_fetch_unit; a second instance near the top of the
// address space exercises the nPC wrap.
module tb_sparc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0100_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic        br_annul;
  logic [31:0] br_target;
  logic        imem_ack;

  logic        imem_req,  imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic [31:0] if_pc, if_pc2, if_npc, if_npc2, if_instr, if_instr2;
  logic        if_valid, if_valid2, if_id_le, if_id_le2, fetch_err, fetch_err2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Memory model: instruction word is a tag XOR its address
  assign imem_rdata  = 32'hA500_0000 ^ imem_addr;
  assign imem_rdata2 = 32'hA500_0000 ^ imem_addr2;

  sparc_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_annul(br_annul),
    .br_target(br_target), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_pc(if_pc), .if_npc(if_npc), .if_instr(if_instr),
    .if_valid(if_valid), .if_id_le(if_id_le), .fetch_err(fetch_err)
  );

  sparc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP), .ACK_TIMEOUT(15)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_annul(br_annul),
    .br_target(br_target), .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata2), .if_pc(if_pc2), .if_npc(if_npc2), .if_instr(if_instr2),
    .if_valid(if_valid2), .if_id_le(if_id_le2), .fetch_err(fetch_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b1; br_taken = 1'b0; br_annul = 1'b0;
    br_target = '0; imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_le_stall", 32'(if_id_le), 32'd0);
    stall = 1'b0;
    #1;
    chk("rst_le", 32'(if_id_le), 32'd1);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_err", 32'(fetch_err), 32'd0);

    // Streaming with zero-wait ack
    imem_ack = 1'b1;
    reset = 1'b1;
    @(negedge clk);                                   // N1
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_valid0", 32'(if_valid), 32'd0);
    chk("wrap_addr0", imem_addr2, 32'hFFFF_FFF8);
    @(negedge clk);                                   // N2
    chk("t1_addr4", imem_addr, 32'h4);
    chk("t1_pc0", if_pc, 32'h0);
    chk("t1_npc0", if_npc, 32'h4);
    chk("t1_instr0", if_instr, 32'hA500_0000);
    chk("t1_valid1", 32'(if_valid), 32'd1);
    chk("wrap_addr1", imem_addr2, 32'hFFFF_FFFC);
    @(negedge clk);                                   // N3
    chk("t1_addr8", imem_addr, 32'h8);
    chk("t1_pc4", if_pc, 32'h4);
    chk("wrap_addr2", imem_addr2, 32'h0);
    chk("wrap_npc", if_npc2, 32'h0);

    // Stall for three cycles while fetch of 0x8 completes
    stall = 1'b1;
    @(negedge clk);                                   // N4
    chk("t2_pc8", if_pc, 32'h8);
    chk("t2_req", 32'(imem_req), 32'd0);
    chk("t2_le", 32'(if_id_le), 32'd0);
    chk("t2_addr", imem_addr, 32'hC);
    @(negedge clk);                                   // N5
    chk("t2_hold_pc", if_pc, 32'h8);
    @(negedge clk);                                   // N6
    chk("t2_hold_req", 32'(imem_req), 32'd0);
    chk("t2_hold_pc2", if_pc, 32'h8);
    stall = 1'b0;
    @(negedge clk);                                   // N7
    chk("t2_resume_req", 32'(imem_req), 32'd1);
    chk("t2_resume_addr", imem_addr, 32'hC);
    @(negedge clk);                                   // N8
    chk("t2_pcC", if_pc, 32'hC);
    @(negedge clk);                                   // N9
    chk("t3_addr14", imem_addr, 32'h14);
    chk("t3_pc10", if_pc, 32'h10);

    // Delayed transfer from branch at 0x10 to 0x40
    br_taken = 1'b1; br_annul = 1'b0; br_target = 32'h40;
    @(negedge clk);                                   // N10
    br_taken = 1'b0;
    chk("t3_addr40", imem_addr, 32'h40);
    chk("t3_ds_pc", if_pc, 32'h14);
    chk("t3_ds_valid", 32'(if_valid), 32'd1);
    chk("t3_ds_instr", if_instr, 32'hA500_0014);
    @(negedge clk);                                   // N11
    chk("t3_addr44", imem_addr, 32'h44);
    chk("t3_pc40", if_pc, 32'h40);
    chk("t3_instr40", if_instr, 32'hA500_0040);

    // Reset mid-request; ack during reset is ignored
    imem_ack = 1'b0;
    @(negedge clk);                                   // N12
    chk("t6_pend_req", 32'(imem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_async_req", 32'(imem_req), 32'd0);
    chk("t6_async_addr", imem_addr, 32'h0);
    imem_ack = 1'b1;
    @(negedge clk);                                   // N13
    chk("t6_rst_valid", 32'(if_valid), 32'd0);
    chk("t6_rst_req", 32'(imem_req), 32'd0);
    reset = 1'b1;
    @(negedge clk);                                   // N14
    chk("t6_restart_addr", imem_addr, 32'h0);
    chk("t6_restart_valid", 32'(if_valid), 32'd0);
    repeat (5) @(negedge clk);                        // N19
    chk("t4_addr14", imem_addr, 32'h14);
    chk("t4_pc10", if_pc, 32'h10);

    // Annulled transfer with the delay-slot ack two cycles late
    imem_ack = 1'b0; br_taken = 1'b1; br_annul = 1'b1; br_target = 32'h40;
    @(negedge clk);                                   // N20
    br_taken = 1'b0; br_annul = 1'b0;
    chk("t4_stable_addr", imem_addr, 32'h14);
    chk("t4_stable_req", 32'(imem_req), 32'd1);
    @(negedge clk);                                   // N21
    chk("t4_stable_addr2", imem_addr, 32'h14);
    imem_ack = 1'b1;
    @(negedge clk);                                   // N22
    chk("t4_squash_valid", 32'(if_valid), 32'd0);
    chk("t4_squash_instr", if_instr, NOP);
    chk("t4_addr40", imem_addr, 32'h40);
    @(negedge clk);                                   // N23
    chk("t4_pc40", if_pc, 32'h40);
    chk("t4_valid40", 32'(if_valid), 32'd1);

    // Timeout: 15 consecutive cycles without ack
    imem_ack = 1'b0;
    repeat (14) @(negedge clk);
    chk("t5_pre_err", 32'(fetch_err), 32'd0);
    chk("t5_pre_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    chk("t5_err", 32'(fetch_err), 32'd1);
    chk("t5_req", 32'(imem_req), 32'd0);
    chk("t5_valid", 32'(if_valid), 32'd0);
    chk("t5_instr", if_instr, NOP);
    reset = 1'b0;
    #1;
    chk("t5_clear", 32'(fetch_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
